// File: rtl/error_telemetry_tx.sv
`default_nettype none
// ============================================================================
// error_telemetry_tx
// Decimated phase-error capture into a byte FIFO, drained as 8N1 UART frames.
// Revision: 1.0
// ============================================================================
module error_telemetry_tx #(
  parameter int PDET_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 2240,
  parameter int DECIM        = 64
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        ref_i,
  input  logic [PDET_WIDTH-1:0]       error_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state;
  logic                    ref_q;
  logic [DEC_W-1:0]        dec_cnt;
  logic [7:0]              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [BAUD_W-1:0]       baud_cnt;
  logic [2:0]              bit_cnt;
  logic [7:0]              shreg;

  logic signed [PDET_WIDTH-1:0] err_s;
  logic [7:0]              sample;
  logic                    rise;
  logic                    capture;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    baud_done;
  logic                    pop;
  logic                    push;
  logic                    line_bit;

  assign err_s      = error_i;
  assign sample     = 8'(err_s);
  assign rise       = ref_i & ~ref_q;
  assign capture    = enable_i & rise & (dec_cnt == DEC_LAST);
  assign fifo_empty = (fifo_count_o == '0);
  assign fifo_full  = (fifo_count_o == FULL_CNT);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  // A pop in the same edge frees the slot a full-FIFO capture needs.
  assign pop        = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_done));
  assign push       = capture & (~fifo_full | pop);

  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shreg[0];
      default: line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      ref_q   <= 1'b0;
      dec_cnt <= '0;
    end else begin
      ref_q <= ref_i;
      if (!enable_i)
        dec_cnt <= '0;
      else if (rise)
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DEC_W'(1);
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (push)
      mem[wr_ptr] <= sample;
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        fifo_count_o <= fifo_count_o + CNT_W'(1);
      else if (pop && !push)
        fifo_count_o <= fifo_count_o - CNT_W'(1);
      if (capture && !push)
        overflow_o <= 1'b1;
    end
  end

  // Line outputs are registered from the state, so they trail it by one clock.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      tx_o   <= line_bit;
      busy_o <= (state != IDLE);
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_error_telemetry_tx.sv
`default_nettype none
// ============================================================================
// tb_error_telemetry_tx
// Randomized bench: schedules of ref strobes checked against a queue model.
// Revision: 1.0
// ============================================================================
module tb_error_telemetry_tx;

  localparam int CPB   = 4;
  localparam int FD    = 4;
  localparam int PW    = 5;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic          ref_in;
  logic [PW-1:0] err;

  logic       tx_a, busy_a, ovf_a;
  logic [2:0] cnt_a;
  logic       tx_b, busy_b, ovf_b;
  logic [2:0] cnt_b;

  error_telemetry_tx #(.PDET_WIDTH(PW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB), .DECIM(1)) u_dut_a (
    .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .ref_i(ref_in), .error_i(err),
    .tx_o(tx_a), .busy_o(busy_a), .overflow_o(ovf_a), .fifo_count_o(cnt_a)
  );

  error_telemetry_tx #(.PDET_WIDTH(PW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB), .DECIM(3)) u_dut_b (
    .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .ref_i(ref_in), .error_i(err),
    .tx_o(tx_b), .busy_o(busy_b), .overflow_o(ovf_b), .fifo_count_o(cnt_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle stimulus schedule: entry t is what edge t samples.
  bit            sref[$];
  logic [PW-1:0] serr[$];
  bit            sen[$];
  bit            srst[$];

  // Per-cycle observations: entry t is the output just after edge t.
  logic       txl_a[$], busyl_a[$], ovfl_a[$];
  logic [2:0] cntl_a[$];
  logic       txl_b[$], ovfl_b[$];
  logic [2:0] cntl_b[$];

  logic [7:0] rx_bytes[$];
  int         rx_starts[$];
  int         rx_bad;

  logic [7:0] exp_bytes[$];
  int         exp_starts[$];
  int         exp_cnt[$];
  bit         exp_ovf;

  function automatic logic [7:0] sext(input logic [PW-1:0] v);
    int s;
    s = int'(v);
    if (v[PW-1]) s = s - (1 << PW);
    return 8'(s);
  endfunction

  task automatic sched_init(input int n, input bit en_val);
    sref.delete(); serr.delete(); sen.delete(); srst.delete();
    for (int t = 0; t < n; t++) begin
      sref.push_back(1'b0);
      serr.push_back(PW'($urandom));
      sen.push_back(en_val);
      srst.push_back(1'b0);
    end
  endtask

  task automatic sched_edge(input int t, input logic [PW-1:0] v);
    sref[t] = 1'b1;
    serr[t] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; ref_in = 1'b0; err = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic run();
    txl_a.delete(); busyl_a.delete(); ovfl_a.delete(); cntl_a.delete();
    txl_b.delete(); ovfl_b.delete(); cntl_b.delete();
    for (int t = 0; t < sref.size(); t++) begin
      rst = srst[t]; en = sen[t]; ref_in = sref[t]; err = serr[t];
      @(posedge clk);
      #1;
      txl_a.push_back(tx_a); busyl_a.push_back(busy_a); ovfl_a.push_back(ovf_a); cntl_a.push_back(cnt_a);
      txl_b.push_back(tx_b); ovfl_b.push_back(ovf_b); cntl_b.push_back(cnt_b);
    end
    rst = 1'b0; ref_in = 1'b0;
  endtask

  // Reference: FIFO as a queue, transmitter as "free again FRAME clocks after a pop".
  task automatic model(input int decim);
    logic [7:0] q[$];
    int  free_at, dcnt;
    bit  prev_ref, rise, cap;
    exp_bytes.delete(); exp_starts.delete(); exp_cnt.delete();
    exp_ovf = 1'b0; free_at = 0; dcnt = 0; prev_ref = 1'b0;
    for (int t = 0; t < sref.size(); t++) begin
      if (q.size() > 0 && t >= free_at) begin
        exp_bytes.push_back(q.pop_front());
        exp_starts.push_back(t + 1);
        free_at = t + FRAME;
      end
      rise = sref[t] && !prev_ref;
      prev_ref = sref[t];
      cap = 1'b0;
      if (!sen[t]) dcnt = 0;
      else if (rise) begin
        dcnt++;
        if (dcnt == decim) begin
          dcnt = 0;
          cap = 1'b1;
        end
      end
      if (cap) begin
        if (q.size() < FD) q.push_back(sext(serr[t]));
        else exp_ovf = 1'b1;
      end
      exp_cnt.push_back(q.size());
    end
  endtask

  function automatic logic txv(input bit sel, input int i);
    return sel ? txl_b[i] : txl_a[i];
  endfunction

  // UART receiver over the recorded line; also counts any sample that
  // deviates from a clean frame (start 0, constant data bits, stop 1).
  function automatic void decode(input bit sel);
    int n, i;
    logic [7:0] b;
    logic want;
    rx_bytes.delete(); rx_starts.delete(); rx_bad = 0;
    n = sel ? txl_b.size() : txl_a.size();
    i = 0;
    while (i + FRAME <= n) begin
      if (txv(sel, i) !== 1'b1) begin
        for (int k = 0; k < 8; k++) b[k] = txv(sel, i + CPB * (k + 1) + CPB / 2);
        for (int j = 0; j < 10; j++) begin
          want = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
          for (int c = 0; c < CPB; c++)
            if (txv(sel, i + CPB * j + c) !== want) rx_bad++;
        end
        rx_bytes.push_back(b);
        rx_starts.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endfunction

  function automatic int byte_mism();
    int m = 0;
    for (int k = 0; k < rx_bytes.size() && k < exp_bytes.size(); k++)
      if (rx_bytes[k] !== exp_bytes[k] || rx_starts[k] !== exp_starts[k]) m++;
    return m;
  endfunction

  function automatic int cnt_mism(input bit sel);
    int m = 0;
    for (int t = 0; t < exp_cnt.size(); t++)
      if (int'(sel ? cntl_b[t] : cntl_a[t]) !== exp_cnt[t]) m++;
    return m;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (tx_a !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_a); else n_pass++;
    n_checks++; if (cnt_a !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", cnt_a); else n_pass++;
    n_checks++;
    if ({tx_b, busy_b, ovf_b, cnt_b} !== 6'b100000)
      $display("FAIL reset_b: got %b want 100000", {tx_b, busy_b, ovf_b, cnt_b});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [PW-1:0] v;
    int m;
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? 5'b11101 : PW'($urandom);
      do_reset();
      sched_init(50, 1'b1);
      sched_edge(0, v);
      run();
      model(1);
      decode(1'b0);
      m = byte_mism();
      n_checks++;
      if (rx_bytes.size() !== 1 || exp_bytes.size() !== 1 || m !== 0)
        $display("FAIL single_frame[%0d]: got %0d frames (%0d mism) want 1 frame byte %h at %0d",
                 it, rx_bytes.size(), m, exp_bytes[0], exp_starts[0]);
      else n_pass++;
      n_checks++;
      if (rx_starts.size() < 1 || rx_starts[0] !== 2)
        $display("FAIL single_latency[%0d]: got start %0d want 2", it, rx_starts.size() ? rx_starts[0] : -1);
      else n_pass++;
      n_checks++;
      if (busyl_a[1] !== 1'b0 || busyl_a[2] !== 1'b1 || busyl_a[41] !== 1'b1 || busyl_a[42] !== 1'b0)
        $display("FAIL single_busy[%0d]: got %b%b%b%b want 0110", it, busyl_a[1], busyl_a[2], busyl_a[41], busyl_a[42]);
      else n_pass++;
      n_checks++;
      if (rx_bad !== 0) $display("FAIL single_framing[%0d]: got %0d bad samples want 0", it, rx_bad); else n_pass++;
      if (it == 0) begin
        n_checks++;
        if (rx_bytes.size() < 1 || rx_bytes[0] !== 8'hFD)
          $display("FAIL single_neg3: got %h want fd", rx_bytes.size() ? rx_bytes[0] : 8'hxx);
        else n_pass++;
        n_checks++;
        if (cnt_mism(1'b0) !== 0) $display("FAIL single_count: got %0d mism want 0", cnt_mism(1'b0)); else n_pass++;
      end
    end
  endtask

  task automatic test_decimation();
    int m;
    do_reset();
    sched_init(110, 1'b1);
    for (int e = 0; e < 7; e++) sched_edge(2 * e, PW'($urandom));
    run();
    model(3);
    decode(1'b1);
    m = byte_mism();
    n_checks++;
    if (rx_bytes.size() !== 2 || exp_bytes.size() !== 2 || m !== 0)
      $display("FAIL decim_frames: got %0d frames (%0d mism) want 2", rx_bytes.size(), m);
    else n_pass++;
    n_checks++;
    if (rx_bytes.size() < 2 || rx_bytes[0] !== sext(serr[4]) || rx_bytes[1] !== sext(serr[10]))
      $display("FAIL decim_samples: got %0d frames want bytes %h %h", rx_bytes.size(), sext(serr[4]), sext(serr[10]));
    else n_pass++;
    n_checks++;
    if (rx_starts.size() < 2 || rx_starts[1] - rx_starts[0] !== FRAME)
      $display("FAIL decim_gap: got %0d frames want spacing %0d", rx_starts.size(), FRAME);
    else n_pass++;
    n_checks++; if (rx_bad !== 0) $display("FAIL decim_framing: got %0d want 0", rx_bad); else n_pass++;
    n_checks++; if (cnt_mism(1'b1) !== 0) $display("FAIL decim_count: got %0d mism want 0", cnt_mism(1'b1)); else n_pass++;
  endtask

  task automatic test_overflow();
    int m;
    do_reset();
    sched_init(220, 1'b1);
    for (int e = 0; e < 6; e++) sched_edge(8 * e, PW'(e));
    run();
    model(1);
    decode(1'b0);
    m = byte_mism();
    n_checks++;
    if (rx_bytes.size() !== exp_bytes.size() || rx_bytes.size() !== 5 || m !== 0)
      $display("FAIL ovf_frames: got %0d frames (%0d mism) want 5", rx_bytes.size(), m);
    else n_pass++;
    n_checks++;
    if (ovfl_a[39] !== 1'b0 || ovfl_a[40] !== 1'b1)
      $display("FAIL ovf_set_time: got %b%b want 01", ovfl_a[39], ovfl_a[40]);
    else n_pass++;
    n_checks++;
    if (ovfl_a[ovfl_a.size()-1] !== exp_ovf || !exp_ovf)
      $display("FAIL ovf_sticky: got %b want 1", ovfl_a[ovfl_a.size()-1]);
    else n_pass++;
    n_checks++; if (cnt_mism(1'b0) !== 0) $display("FAIL ovf_count: got %0d mism want 0", cnt_mism(1'b0)); else n_pass++;
    n_checks++; if (rx_bad !== 0) $display("FAIL ovf_framing: got %0d want 0", rx_bad); else n_pass++;
  endtask

  task automatic test_full_pop();
    int m;
    do_reset();
    sched_init(250, 1'b1);
    for (int e = 0; e < 5; e++) sched_edge(8 * e, PW'($urandom));
    sched_edge(41, PW'($urandom));
    run();
    model(1);
    decode(1'b0);
    m = byte_mism();
    n_checks++; if (cntl_a[41] !== 3'd4) $display("FAIL fullpop_count: got %0d want 4", cntl_a[41]); else n_pass++;
    n_checks++; if (ovfl_a[ovfl_a.size()-1] !== 1'b0) $display("FAIL fullpop_ovf: got 1 want 0"); else n_pass++;
    n_checks++;
    if (rx_bytes.size() !== 6 || exp_bytes.size() !== 6 || m !== 0)
      $display("FAIL fullpop_frames: got %0d frames (%0d mism) want 6", rx_bytes.size(), m);
    else n_pass++;
    n_checks++; if (cnt_mism(1'b0) !== 0) $display("FAIL fullpop_trace: got %0d mism want 0", cnt_mism(1'b0)); else n_pass++;
  endtask

  task automatic test_enable();
    int m;
    do_reset();
    sched_init(30, 1'b0);
    for (int e = 0; e < 10; e++) sched_edge(2 * e, PW'($urandom));
    run();
    model(1);
    decode(1'b0);
    n_checks++; if (rx_bytes.size() !== 0) $display("FAIL enable_off_frames: got %0d want 0", rx_bytes.size()); else n_pass++;
    n_checks++; if (cnt_mism(1'b0) !== 0) $display("FAIL enable_off_count: got %0d mism want 0", cnt_mism(1'b0)); else n_pass++;
    do_reset();
    sched_init(110, 1'b1);
    for (int t = 1; t < 16; t++) sen[t] = 1'b0;
    sched_edge(0, PW'($urandom));
    sched_edge(4, PW'($urandom));
    sched_edge(8, PW'($urandom));
    sched_edge(12, PW'($urandom));
    sched_edge(20, PW'($urandom));
    run();
    model(1);
    decode(1'b0);
    m = byte_mism();
    n_checks++;
    if (rx_bytes.size() !== 2 || exp_bytes.size() !== 2 || m !== 0)
      $display("FAIL enable_toggle_frames: got %0d frames (%0d mism) want 2", rx_bytes.size(), m);
    else n_pass++;
    n_checks++; if (rx_bad !== 0) $display("FAIL enable_toggle_framing: got %0d want 0", rx_bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0;
    int m;
    do_reset();
    sched_init(21, 1'b1);
    for (int e = 0; e < 6; e++) sched_edge(2 * e, PW'($urandom));
    srst[20] = 1'b1;
    run();
    b0 = sext(serr[0]);
    n_checks++;
    if ({txl_a[19], busyl_a[19], ovfl_a[19], cntl_a[19]} !== {b0[3], 1'b1, 1'b1, 3'd4})
      $display("FAIL rstmid_before: got %b want %b", {txl_a[19], busyl_a[19], ovfl_a[19], cntl_a[19]}, {b0[3], 5'b11100});
    else n_pass++;
    n_checks++;
    if ({txl_a[20], busyl_a[20], ovfl_a[20], cntl_a[20]} !== 6'b100000)
      $display("FAIL rstmid_after: got %b want 100000", {txl_a[20], busyl_a[20], ovfl_a[20], cntl_a[20]});
    else n_pass++;
    sched_init(50, 1'b1);
    sched_edge(3, PW'($urandom));
    run();
    model(1);
    decode(1'b0);
    m = byte_mism();
    n_checks++;
    if (rx_bytes.size() !== 1 || exp_bytes.size() !== 1 || m !== 0 || rx_bad !== 0)
      $display("FAIL rstmid_fresh: got %0d frames (%0d mism, %0d bad) want 1 byte %h",
               rx_bytes.size(), m, rx_bad, sext(serr[3]));
    else n_pass++;
    n_checks++; if (ovfl_a[ovfl_a.size()-1] !== 1'b0) $display("FAIL rstmid_ovf: got 1 want 0"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_decimation();
    test_overflow();
    test_full_pop();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
